// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch unit with request/response memory port and decode FIFO
//
// Fetches 32-bit instruction words starting at RESET_PC, keeping at most one
// memory request outstanding, and buffers each returned word together with its
// PC in a FIFO_DEPTH-entry FIFO that decode drains over a valid/ready handshake.
// A pc_load pulse redirects fetch to next_pc (word aligned), flushes the FIFO and
// marks any in-flight response to be discarded.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   next_pc[31:0], pc_load     redirect target and 1-cycle redirect strobe
//   imem_req_valid/ready/addr  fetch request channel (valid/ready)
//   imem_rsp_valid/data        fetch response channel (valid only, in order)
//   inst_valid/ready           FIFO head handshake toward decode
//   inst[31:0], inst_pc[31:0]  instruction and its PC at the FIFO head (0 when empty)
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_load,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_STALL} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_pc;
  logic        drop, drop_nxt;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [31:0]   mem_pc   [FIFO_DEPTH];

  logic req_fire, push, pop;

  // Request valid is forced low while reset is held, independent of the clock.
  assign imem_req_valid = rst_n & (state == S_REQ);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? mem_inst[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 32'h0;

  // A redirect flushes the FIFO, so it suppresses both the pop and the push of that cycle.
  assign pop       = inst_valid & inst_ready & ~pc_load;
  assign push      = (state == S_WAIT) & imem_rsp_valid & ~drop & ~pc_load;
  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;
    case (state)
      S_REQ: begin
        if (req_fire) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_nxt = 1'b0;
          if (!drop) fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt = (count_nxt < DEPTH_C) ? S_REQ : S_STALL;
        end
      end
      S_STALL: begin
        // Wait one cycle after a slot frees so REQ is always entered with room.
        if (count < DEPTH_C) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase

    if (pc_load) begin
      fetch_pc_nxt = next_pc & 32'hFFFF_FFFC;
      case (state)
        S_REQ:   drop_nxt = req_fire;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0;
      drop     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      drop     <= drop_nxt;
      if (req_fire) req_pc <= fetch_pc;
      if (pc_load) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_nxt;
      end
    end
  end

  // Payload storage needs no reset: it is only observed while inst_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_rsp_data;
      mem_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule
